// File: rtl/tmds_rx_decoder_if.sv
// Bus between one TMDS channel deserializer and its decoder: the raw word in,
// and the decoded character, lock status and slip offset out.
interface tmds_rx_decoder_if;
    logic [9:0] raw_in;
    logic [7:0] data_out;
    logic [1:0] ctrl_out;
    logic       de;
    logic       locked;
    logic [3:0] offset;

    modport master (
        output raw_in,
        input  data_out,
        input  ctrl_out,
        input  de,
        input  locked,
        input  offset
    );

    modport slave (
        input  raw_in,
        output data_out,
        output ctrl_out,
        output de,
        output locked,
        output offset
    );
endinterface

// File: rtl/tmds_rx_decoder.sv
// TMDS channel decoder: bit-slip alignment from control-token runs, then
// 2-stage decode of each 10-bit character to pixel data or a control code.
module tmds_rx_decoder #(
    parameter int LOCK_RUN = 8,
    parameter int TIMEOUT  = 4096,
    parameter int CNT_W    = 13
) (
    input  logic                pixclk,
    input  logic                rst_n,
    tmds_rx_decoder_if.slave    rx
);

    typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

    localparam logic [7:0]       RUN_MAX  = 8'(LOCK_RUN);
    localparam logic [CNT_W-1:0] TCNT_END = CNT_W'(TIMEOUT - 1);

    // {is_token, code} for one aligned character
    function automatic logic [2:0] token_lookup(input logic [9:0] w);
        logic [2:0] r;
        case (w)
            10'b1101010100: r = 3'b100;
            10'b0010101011: r = 3'b101;
            10'b0101010100: r = 3'b110;
            10'b1010101011: r = 3'b111;
            default:        r = 3'b000;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] tmds_decode(input logic [9:0] w);
        logic [7:0] d;
        logic [7:0] q;
        d    = w[9] ? ~w[7:0] : w[7:0];
        q    = 8'h00;
        q[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = w[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
        return q;
    endfunction

    state_t           state_q;
    logic [9:0]       raw_prev_q;
    logic [9:0]       w1_q;
    logic             tok1_q;
    logic [7:0]       data_out_q;
    logic [1:0]       ctrl_out_q;
    logic             de_q;
    logic             locked_q;
    logic [3:0]       offset_q;
    logic [7:0]       run_q;
    logic [CNT_W-1:0] tcnt_q;

    logic [19:0]      win_s;
    logic [9:0]       w_s;
    logic [2:0]       tok_info_s;
    logic [2:0]       tok1_info_s;
    logic [7:0]       data_d;
    logic [1:0]       ctrl_d;
    logic             de_d;

    // The newer word sits above the older one, so offset 0 is raw_prev as-is.
    assign win_s       = {rx.raw_in, raw_prev_q};
    assign w_s         = 10'(win_s >> offset_q);
    assign tok_info_s  = token_lookup(w_s);
    assign tok1_info_s = token_lookup(w1_q);

    // Stage-2 next values: tokens update ctrl only, data updates pixel only
    always_comb begin
        data_d = data_out_q;
        ctrl_d = ctrl_out_q;
        de_d   = 1'b0;
        if (tok1_q) begin
            ctrl_d = tok1_info_s[1:0];
        end else begin
            data_d = tmds_decode(w1_q);
            de_d   = locked_q;
        end
    end

    // Word history and the two pipeline stages
    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            raw_prev_q <= 10'd0;
            w1_q       <= 10'd0;
            tok1_q     <= 1'b0;
            data_out_q <= 8'd0;
            ctrl_out_q <= 2'd0;
            de_q       <= 1'b0;
        end else begin
            raw_prev_q <= rx.raw_in;
            w1_q       <= w_s;
            tok1_q     <= tok_info_s[2];
            data_out_q <= data_d;
            ctrl_out_q <= ctrl_d;
            de_q       <= de_d;
        end
    end

    // Alignment FSM: token-run lock, timeout-driven bit slip and lock loss
    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= SEARCH;
            locked_q <= 1'b0;
            offset_q <= 4'd0;
            run_q    <= 8'd0;
            tcnt_q   <= '0;
        end else begin
            case (state_q)
                SEARCH: begin
                    if (tok1_q) begin
                        tcnt_q <= '0;
                        if (run_q >= (RUN_MAX - 8'd1)) begin
                            run_q    <= RUN_MAX;
                            state_q  <= LOCKED;
                            locked_q <= 1'b1;
                        end else begin
                            run_q <= run_q + 8'd1;
                        end
                    end else if (tcnt_q == TCNT_END) begin
                        offset_q <= (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
                        tcnt_q   <= '0;
                        run_q    <= 8'd0;
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                        run_q  <= 8'd0;
                    end
                end
                LOCKED: begin
                    if (tok1_q) begin
                        tcnt_q <= '0;
                    end else if (tcnt_q == TCNT_END) begin
                        state_q  <= SEARCH;
                        locked_q <= 1'b0;
                        run_q    <= 8'd0;
                        tcnt_q   <= '0;
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q  <= SEARCH;
                    locked_q <= 1'b0;
                    run_q    <= 8'd0;
                    tcnt_q   <= '0;
                end
            endcase
        end
    end

    assign rx.data_out = data_out_q;
    assign rx.ctrl_out = ctrl_out_q;
    assign rx.de       = de_q;
    assign rx.locked   = locked_q;
    assign rx.offset   = offset_q;

endmodule

// File: tb/tb_tmds_rx_decoder.sv
// Directed bench for tmds_rx_decoder: lock timing, decode table, bit-slip
// search, lock loss, offset wrap and asynchronous reset.
module tb_tmds_rx_decoder;

    localparam logic [9:0] T0  = 10'b1101010100;
    localparam logic [9:0] T1  = 10'b0010101011;
    localparam logic [9:0] T2  = 10'b0101010100;
    localparam logic [9:0] T3  = 10'b1010101011;
    localparam logic [9:0] DFE = 10'b1011111111;
    localparam logic [9:0] D00 = 10'b0100000000;
    localparam logic [9:0] D01 = 10'b0111111111;
    localparam logic [9:0] DFF = 10'b1000000000;

    logic pixclk = 1'b0;
    logic rst_n  = 1'b0;
    int   tests_run    = 0;
    int   tests_failed = 0;

    logic [9:0] prev_char = 10'd0;
    int         sh        = 0;

    tmds_rx_decoder_if rx ();

    tmds_rx_decoder dut (
        .pixclk (pixclk),
        .rst_n  (rst_n),
        .rx     (rx)
    );

    always #5 pixclk = ~pixclk;

    task automatic chk(input string tag, input int obs, input int exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic [9:0] w);
        rx.raw_in = w;
        @(posedge pixclk);
        #1;
    endtask

    // Emit one character into a serial stream delayed by sh bits.
    task automatic send(input logic [9:0] c);
        logic [19:0] cat;
        cat       = {c, prev_char};
        prev_char = c;
        tick(10'(cat >> (10 - sh)));
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        rx.raw_in = 10'd0;
        prev_char = 10'd0;
        repeat (3) @(posedge pixclk);
        #4;
        rst_n = 1'b1;
    endtask

    logic [9:0] vec   [8];
    int         isctl [8];
    int         expv  [8];
    int         expd  [8];
    int         n;
    int         steps;
    int         prev_off;

    initial begin
        vec = '{DFE, T1, D00, T2, D01, T3, DFF, T0};
        isctl = '{0, 1, 0, 1, 0, 1, 0, 1};
        expv  = '{8'hFE, 1, 8'h00, 2, 8'h01, 3, 8'hFF, 0};
        expd  = '{8'hFE, 8'hFE, 8'h00, 8'h00, 8'h01, 8'h01, 8'hFF, 8'hFF};

        // Reset state and aligned lock timing
        sh = 0;
        rx.raw_in = 10'd0;
        #2;
        chk("reset_outputs", {rx.data_out, rx.ctrl_out, rx.de, rx.locked, rx.offset}, 0);
        do_reset();
        repeat (9) send(T0);
        chk("lock_not_before_8", rx.locked, 0);
        send(T0);
        chk("lock_after_8", rx.locked, 1);
        chk("lock_offset0", rx.offset, 0);
        repeat (10) send(T0);
        chk("blank_ctrl00", rx.ctrl_out, 0);
        chk("blank_de0", rx.de, 0);
        send(D00);
        send(D00);
        chk("de_not_yet", rx.de, 0);
        send(D00);
        chk("de_after_2", rx.de, 1);
        chk("data_00", rx.data_out, 8'h00);

        // Decode table, including hold of the unused field
        for (int i = 0; i < 8; i++) begin
            repeat (3) send(vec[i]);
            if (isctl[i] != 0) begin
                chk("tbl_ctrl", rx.ctrl_out, expv[i]);
                chk("tbl_ctrl_de", rx.de, 0);
            end else begin
                chk("tbl_data_de", rx.de, 1);
            end
            chk("tbl_data", rx.data_out, expd[i]);
        end

        // Stream delayed by 3 bits: search steps offset up to 3
        sh = 3;
        do_reset();
        steps    = 0;
        prev_off = 0;
        for (int c = 0; c < 20000 && !rx.locked; c++) begin
            send(T0);
            if (int'(rx.offset) != prev_off) begin
                chk("slip_step", rx.offset, prev_off + 1);
                steps++;
                prev_off = int'(rx.offset);
            end
        end
        chk("sh3_locked", rx.locked, 1);
        chk("sh3_offset", rx.offset, 3);
        chk("sh3_steps", steps, 3);
        for (int i = 0; i < 8; i += 2) begin
            repeat (4) send(vec[i]);
            chk("sh3_pixel", rx.data_out, expv[i]);
            chk("sh3_de", rx.de, 1);
        end

        // Realign to a 5-bit delay, then starve tokens to drop lock
        sh = 5;
        for (int c = 0; c < 20000 && !(rx.locked && rx.offset == 4'd5); c++) begin
            send(T0);
        end
        chk("sh5_locked", rx.locked, 1);
        chk("sh5_offset", rx.offset, 5);
        repeat (10) send(D00);
        chk("sh5_de", rx.de, 1);
        n = 10;
        while (rx.locked && n < 5000) begin
            send(D00);
            n++;
        end
        chk("lol_not_early", int'(n > 4000), 1);
        chk("lol_not_late", int'(n <= 4200), 1);
        chk("lol_offset_kept", rx.offset, 5);
        repeat (20) send(D00);
        chk("lol_de0", rx.de, 0);
        chk("lol_unlocked", rx.locked, 0);

        // Garbage to offset 9, then aligned tokens force the wrap to 0
        for (int c = 0; c < 20000 && rx.offset != 4'd9; c++) begin
            tick(10'h3FF);
        end
        chk("wrap_at9", rx.offset, 9);
        chk("wrap_unlocked", rx.locked, 0);
        sh = 0;
        for (int c = 0; c < 6000 && !rx.locked; c++) begin
            send(T0);
        end
        chk("wrap_locked", rx.locked, 1);
        chk("wrap_offset0", rx.offset, 0);

        // Asynchronous reset between edges while locked
        repeat (3) send(DFE);
        repeat (3) send(T3);
        chk("pre_rst_data", rx.data_out, 8'hFE);
        chk("pre_rst_ctrl", rx.ctrl_out, 3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_async", {rx.data_out, rx.ctrl_out, rx.de, rx.locked, rx.offset}, 0);
        #2;
        rst_n = 1'b1;
        repeat (9) send(T0);
        chk("relock_not_before_8", rx.locked, 0);
        send(T0);
        chk("relock_after_8", rx.locked, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
